// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use and multicycle stalls, redirect flushes.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int NUM_SRC      = 2,
    parameter int REG_AW       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] d_rs,
    input  logic [NUM_SRC-1:0]        d_rs_used,
    input  logic [NUM_SRC*REG_AW-1:0] e_rs,
    input  logic [REG_AW-1:0]         e_rd,
    input  logic                      e_reg_write,
    input  logic                      e_is_load,
    input  logic [REG_AW-1:0]         m_rd,
    input  logic                      m_reg_write,
    input  logic [REG_AW-1:0]         w_rd,
    input  logic                      w_reg_write,
    input  logic                      e_redirect,
    input  logic                      mc_start,
    input  logic                      mc_done,
    output logic                      pc_en,
    output logic                      f_d_en,
    output logic                      d_e_en,
    output logic                      f_d_flush,
    output logic                      d_e_flush,
    output logic                      e_m_bubble,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MC_WAIT    = 2'b10
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       w_load_use;

    assign state = r_state;

    // The M stage holds the younger result, so it wins over W.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (m_reg_write && (m_rd != '0) && (m_rd == e_rs[i*REG_AW +: REG_AW]))
                fwd_sel[2*i +: 2] = 2'b01;
            else if (w_reg_write && (w_rd != '0) && (w_rd == e_rs[i*REG_AW +: REG_AW]))
                fwd_sel[2*i +: 2] = 2'b10;
        end
    end

    always_comb begin
        w_load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (d_rs_used[i] && (d_rs[i*REG_AW +: REG_AW] == e_rd))
                w_load_use = 1'b1;
        end
        w_load_use = w_load_use && e_is_load && e_reg_write && (e_rd != '0);
    end

    // Outputs are forced to free-running values while rst is low.
    always_comb begin
        pc_en       = 1'b1;
        f_d_en      = 1'b1;
        d_e_en      = 1'b1;
        f_d_flush   = 1'b0;
        d_e_flush   = 1'b0;
        e_m_bubble  = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (rst) begin
            case (r_state)
                RUN: begin
                    if (e_redirect) begin
                        f_d_flush = 1'b1;
                        d_e_flush = 1'b1;
                    end else if (mc_start && !mc_done) begin
                        pc_en       = 1'b0;
                        f_d_en      = 1'b0;
                        d_e_en      = 1'b0;
                        e_m_bubble  = 1'b1;
                        w_state_nxt = MC_WAIT;
                    end else if (w_load_use) begin
                        pc_en     = 1'b0;
                        f_d_en    = 1'b0;
                        d_e_flush = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            w_state_nxt = LOAD_STALL;
                            w_cnt_nxt   = 3'(LOAD_BUBBLES - 1);
                        end
                    end
                end
                LOAD_STALL: begin
                    pc_en     = 1'b0;
                    f_d_en    = 1'b0;
                    d_e_flush = 1'b1;
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                MC_WAIT: begin
                    if (mc_done) begin
                        w_state_nxt = RUN;
                    end else begin
                        pc_en      = 1'b0;
                        f_d_en     = 1'b0;
                        d_e_en     = 1'b0;
                        e_m_bubble = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (f_d_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, 2, number of source-register ports per instruction.
REQ-002 SHALL have parameter REG_AW, 5, register-address width.
REQ-003 SHALL have parameter LOAD_BUBBLES, 1, number of bubbles per load-use hazard (1..7).
REQ-004 SHALL have parameter CNT_W, 32, performance-counter width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 d_rs  in  NUM_SRC*REG_AW  decode-stage source addresses (port i at bits [i*REG_AW +: REG_AW]).
REQ-008 d_rs_used  in  NUM_SRC  decode source i is actually read.
REQ-009 e_rs  in  NUM_SRC*REG_AW  execute-stage source addresses.
REQ-010 e_rd, e_reg_write, e_is_load  in  REG_AW,1,1  execute destination, write enable, load flag.
REQ-011 m_rd, m_reg_write  in  REG_AW,1  memory-stage destination and write enable.
REQ-012 w_rd, w_reg_write  in  REG_AW,1  writeback destination and write enable.
REQ-013 e_redirect  in  1  branch/jump resolved taken in execute.
REQ-014 mc_start, mc_done  in  1,1  multicycle execute op present / result ready.
REQ-015 pc_en, f_d_en, d_e_en  out  1 each  pipeline-register enables.
REQ-016 f_d_flush, d_e_flush, e_m_bubble  out  1 each  insert NOP into F/D, D/E, E/M.
REQ-017 fwd_sel  out  2*NUM_SRC  per-source execute mux select: 00 regfile, 01 M result, 10 W result.
REQ-018 stall_cnt, flush_cnt  out  CNT_W each  performance counters.
REQ-019 state  out  2  FSM state: 00 RUN, 01 LOAD_STALL, 10 MC_WAIT.

Function
REQ-020 fwd_sel[i] SHALL be combinational: 01 if m_reg_write, m_rd!=0, m_rd==e_rs[i]; else 10 if w_reg_write, w_rd!=0, w_rd==e_rs[i]; else 00 (M priority over W).
REQ-021 Load-use hazard SHALL be: e_is_load, e_reg_write, e_rd!=0, and any i with d_rs_used[i], d_rs[i]==e_rd.
REQ-022 RUN, no event: pc_en=f_d_en=d_e_en=1, all flush/bubble outputs 0.
REQ-023 RUN, e_redirect: pc_en=1, f_d_flush=1, d_e_flush=1, remain RUN; redirect SHALL override load-use and mc_start.
REQ-024 RUN, load-use: pc_en=0, f_d_en=0, d_e_flush=1 this cycle; if LOAD_BUBBLES>1 go LOAD_STALL with counter=LOAD_BUBBLES-1, else stay RUN.
REQ-025 LOAD_STALL: same outputs as REQ-024 each cycle, counter decrements; on counter==1 return RUN next edge; total bubbles exactly LOAD_BUBBLES.
REQ-026 RUN, mc_start without mc_done: pc_en=f_d_en=d_e_en=0, e_m_bubble=1, go MC_WAIT.
REQ-027 MC_WAIT: hold enables 0, e_m_bubble=1 until mc_done; mc_done cycle: enables 1, e_m_bubble=0, return RUN.
REQ-028 mc_start with mc_done same cycle in RUN SHALL cause no stall.
REQ-029 mc_start with load-use in RUN: mc_start SHALL win; load-use rechecked after release.
REQ-030 e_redirect in LOAD_STALL or MC_WAIT SHALL be ignored (E held, value re-presented later).

Reset
REQ-031 rst low SHALL immediately force state=RUN, counter=0, stall_cnt=0, flush_cnt=0.
REQ-032 During reset outputs SHALL be pc_en=f_d_en=d_e_en=1, flush/bubble 0; reset mid-stall abandons the stall.

Configuration
REQ-033 With HAZARD_PERF_CNT_EN defined: stall_cnt +1 per cycle with pc_en=0, flush_cnt +1 per redirect cycle, both saturating at all-ones.
REQ-034 Without HAZARD_PERF_CNT_EN: stall_cnt and flush_cnt SHALL be constant 0, no counter flops.

Verification
REQ-035 e_rs[0]=5, m_rd=5, w_rd=5, both writes 1 -> fwd_sel[1:0]=01; m_reg_write=0 -> 10; m_rd=0,w_rd=0 -> 00.
REQ-036 LOAD_BUBBLES=3, load e_rd=7, d_rs[1]=7 used -> pc_en=0 for exactly 3 cycles, d_e_flush=1 each, then RUN.
REQ-037 e_redirect=1 with simultaneous load-use -> pc_en=1, f_d_flush=d_e_flush=1, state stays RUN, flush_cnt +1.
REQ-038 mc_start=1, mc_done after 4 cycles -> enables 0 for 4 cycles, e_m_bubble=1, release on mc_done cycle, stall_cnt=4.
REQ-039 rst low during MC_WAIT cycle 2 -> state=RUN, counters 0, enables 1 asynchronously.
REQ-040 Build without HAZARD_PERF_CNT_EN, repeat REQ-038 -> stall_cnt=0, flush_cnt=0.
